// File: rtl/uio_prbs_pkg.sv
// Shared types and constants for the user-IO PRBS-31 generator/checker.
package uio_prbs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } prbs_state_e;

  // Polynomial x^31 + x^28 + 1
  localparam int PRBS_TAP_HI = 31;
  localparam int PRBS_TAP_LO = 28;

  localparam logic [30:0] PRBS_DEFAULT_SEED = 31'h7FFF_FFFF;
  localparam logic [31:0] NO_ERR_IDX        = 32'hFFFF_FFFF;
  localparam logic [31:0] CNT_MAX           = 32'hFFFF_FFFF;

endpackage

// File: rtl/uio_prbs_gen_chk_if.sv
// Request/response channels of one user-IO port.
// master = traffic side (generator/checker), slave = user-IO black box.
interface uio_prbs_gen_chk_if #(
  parameter int UIO_PORTS_WIDTH = 128
);
  import uio_prbs_pkg::*;

  logic                       uio_rq_vld;
  logic [UIO_PORTS_WIDTH-1:0] uio_rq_data;
  logic                       uio_rq_afull;
  logic                       uio_rs_vld;
  logic [UIO_PORTS_WIDTH-1:0] uio_rs_data;
  logic                       uio_rs_afull;

  modport master (
    output uio_rq_vld, uio_rq_data, uio_rs_afull,
    input  uio_rq_afull, uio_rs_vld, uio_rs_data
  );

  modport slave (
    input  uio_rq_vld, uio_rq_data, uio_rs_afull,
    output uio_rq_afull, uio_rs_vld, uio_rs_data
  );
endinterface

// File: rtl/prbs31_word.sv
// Combinational PRBS-31 word builder: runs WIDTH LFSR steps from 'state'.
// Bit 0 of 'word' is the first generated bit; 'next_state' is the LFSR
// after the whole word.
module prbs31_word
  import uio_prbs_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic [30:0]      state,
  output logic [WIDTH-1:0] word,
  output logic [30:0]      next_state
);

  logic [30:0] lfsr_s;
  logic        bit_s;

  // Unroll WIDTH shift steps of the Fibonacci LFSR.
  always_comb begin
    lfsr_s = state;
    bit_s  = 1'b0;
    word   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bit_s   = lfsr_s[PRBS_TAP_HI-1] ^ lfsr_s[PRBS_TAP_LO-1];
      word[i] = bit_s;
      lfsr_s  = {lfsr_s[29:0], bit_s};
    end
    next_state = lfsr_s;
  end

endmodule

// File: rtl/uio_prbs_gen_chk.sv
// PRBS-31 traffic generator/checker for one user-IO port.
// Sends a seeded PRBS stream on the request channel, checks the looped-back
// stream on the response channel and reports counts / first error index.
// Optional build macro: UIO_PRBS_ERR_INJ_EN (one-shot bit-0 error injection).
module uio_prbs_gen_chk
  import uio_prbs_pkg::*;
#(
  parameter int          UIO_PORTS_WIDTH = 128,
  parameter logic [30:0] PRBS_SEED       = PRBS_DEFAULT_SEED,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd65536
) (
  input  logic                clk_per,
  input  logic                reset_per_n,
  input  logic                i_start,
  input  logic [31:0]         i_num_words,
  input  logic                i_inj_err,
  uio_prbs_gen_chk_if.master  uio,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_timeout,
  output logic [31:0]         o_tx_cnt,
  output logic [31:0]         o_rx_cnt,
  output logic [31:0]         o_err_cnt,
  output logic [31:0]         o_first_err_idx,
  output logic                o_rx_unexp
);

  prbs_state_e                state_r;
  logic [31:0]                num_words_r;
  logic [31:0]                to_cnt_r;
  logic [30:0]                gen_state_r;
  logic [30:0]                chk_state_r;
  logic                       rq_vld_r;
  logic [UIO_PORTS_WIDTH-1:0] rq_data_r;

  logic [UIO_PORTS_WIDTH-1:0] gen_word_s;
  logic [UIO_PORTS_WIDTH-1:0] chk_word_s;
  logic [UIO_PORTS_WIDTH-1:0] tx_data_s;
  logic [30:0]                gen_next_s;
  logic [30:0]                chk_next_s;
  logic                       send_s;
  logic                       rx_s;
  logic                       mismatch_s;
  logic [31:0]                rx_cnt_nxt_s;
  logic [31:0]                to_cnt_nxt_s;

  prbs31_word #(.WIDTH(UIO_PORTS_WIDTH)) u_gen (
    .state      (gen_state_r),
    .word       (gen_word_s),
    .next_state (gen_next_s)
  );

  prbs31_word #(.WIDTH(UIO_PORTS_WIDTH)) u_chk (
    .state      (chk_state_r),
    .word       (chk_word_s),
    .next_state (chk_next_s)
  );

  assign uio.uio_rq_vld   = rq_vld_r;
  assign uio.uio_rq_data  = rq_data_r;
  assign uio.uio_rs_afull = 1'b0;   // checker never back-pressures

`ifdef UIO_PRBS_ERR_INJ_EN
  logic inj_armed_r;
  logic inj_arm_s;

  // A pulse arms immediately so it also applies to a word sent this cycle.
  always_comb begin
    inj_arm_s = inj_armed_r | i_inj_err;
    tx_data_s = gen_word_s ^ {{(UIO_PORTS_WIDTH-1){1'b0}}, inj_arm_s};
  end

  // One-shot: cleared by the word that carries the flipped bit.
  always_ff @(posedge clk_per or negedge reset_per_n) begin
    if (!reset_per_n) begin
      inj_armed_r <= 1'b0;
    end else if (send_s) begin
      inj_armed_r <= 1'b0;
    end else begin
      inj_armed_r <= inj_arm_s;
    end
  end
`else
  logic unused_inj_s;
  assign unused_inj_s = i_inj_err;

  // Transmit the generator word unmodified.
  always_comb begin
    tx_data_s = gen_word_s;
  end
`endif

  // Per-cycle send/receive decisions and next counter values.
  always_comb begin
    send_s       = (state_r == ST_RUN) && !uio.uio_rq_afull && (o_tx_cnt < num_words_r);
    rx_s         = ((state_r == ST_RUN) || (state_r == ST_DRAIN)) && uio.uio_rs_vld;
    mismatch_s   = rx_s && (uio.uio_rs_data != chk_word_s);
    rx_cnt_nxt_s = rx_s ? (o_rx_cnt + 32'd1) : o_rx_cnt;
    to_cnt_nxt_s = (rx_s || send_s) ? 32'd0 : (to_cnt_r + 32'd1);
  end

  // Run-control FSM with registered request channel and status outputs.
  always_ff @(posedge clk_per or negedge reset_per_n) begin
    if (!reset_per_n) begin
      state_r         <= ST_IDLE;
      num_words_r     <= 32'd0;
      to_cnt_r        <= 32'd0;
      gen_state_r     <= PRBS_SEED;
      chk_state_r     <= PRBS_SEED;
      rq_vld_r        <= 1'b0;
      rq_data_r       <= '0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_timeout       <= 1'b0;
      o_tx_cnt        <= 32'd0;
      o_rx_cnt        <= 32'd0;
      o_err_cnt       <= 32'd0;
      o_first_err_idx <= NO_ERR_IDX;
      o_rx_unexp      <= 1'b0;
    end else begin
      rq_vld_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (uio.uio_rs_vld) begin
            o_rx_unexp <= 1'b1;
          end
          if (i_start) begin
            num_words_r     <= i_num_words;
            to_cnt_r        <= 32'd0;
            gen_state_r     <= PRBS_SEED;
            chk_state_r     <= PRBS_SEED;
            o_tx_cnt        <= 32'd0;
            o_rx_cnt        <= 32'd0;
            o_err_cnt       <= 32'd0;
            o_first_err_idx <= NO_ERR_IDX;
            o_timeout       <= 1'b0;
            o_rx_unexp      <= 1'b0;
            if (i_num_words == 32'd0) begin
              state_r <= ST_DONE;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
            end else begin
              state_r <= ST_RUN;
              o_busy  <= 1'b1;
              o_done  <= 1'b0;
            end
          end
        end
        ST_RUN, ST_DRAIN: begin
          if (send_s) begin
            rq_vld_r    <= 1'b1;
            rq_data_r   <= tx_data_s;
            gen_state_r <= gen_next_s;
            o_tx_cnt    <= o_tx_cnt + 32'd1;
          end
          if (rx_s) begin
            o_rx_cnt    <= rx_cnt_nxt_s;
            chk_state_r <= chk_next_s;
            if (mismatch_s) begin
              if (o_err_cnt != CNT_MAX) begin
                o_err_cnt <= o_err_cnt + 32'd1;
              end
              if (o_err_cnt == 32'd0) begin
                o_first_err_idx <= o_rx_cnt;
              end
            end
          end
          to_cnt_r <= to_cnt_nxt_s;
          if (to_cnt_nxt_s >= TIMEOUT_CYCLES) begin
            o_timeout <= 1'b1;
            state_r   <= ST_DONE;
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
          end else if ((state_r == ST_RUN) && send_s && ((o_tx_cnt + 32'd1) == num_words_r)) begin
            state_r <= ST_DRAIN;
          end else if ((state_r == ST_DRAIN) && (rx_cnt_nxt_s == num_words_r)) begin
            state_r <= ST_DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
